// File: rtl/alu_exec_stage.sv
// Execute stage: combinational 32-bit ALU feeding the EX/MEM pipeline register,
// plus a sticky signed-overflow exception record for the hazard/exception unit.
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  ALUoper,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [15:0] imm16,
  input  logic [4:0]  shamt,
  input  logic        in_wreg,
  input  logic [4:0]  in_waddr,
  input  logic [31:0] in_pc,
  input  logic        stall,
  input  logic        flush,
  input  logic        exc_ack,
  output logic        out_valid,
  output logic        out_wreg,
  output logic [4:0]  out_waddr,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        exc_pending,
  output logic [31:0] exc_epc
);

  typedef enum logic [4:0] {
    OP_AND   = 5'd0,  OP_OR    = 5'd1,  OP_ADD   = 5'd2,  OP_SLL   = 5'd3,
    OP_SRL   = 5'd4,  OP_SRA   = 5'd5,  OP_SUB   = 5'd6,  OP_SLT   = 5'd7,
    OP_NOR   = 5'd8,  OP_XOR   = 5'd9,  OP_ADDU  = 5'd10, OP_SLTU  = 5'd11,
    OP_SLLV  = 5'd12, OP_SRLV  = 5'd13, OP_SUBU  = 5'd14, OP_SRAV  = 5'd15,
    OP_ADDIU = 5'd16, OP_XORI  = 5'd17, OP_LUI   = 5'd18, OP_SLTI  = 5'd19,
    OP_SLTIU = 5'd20
  } alu_op_e;

  logic [31:0] imm_sx, imm_zx, sum, diff, imm_sum, result;
  logic        ovf, fault, take_exc;

  assign imm_sx  = {{16{imm16[15]}}, imm16};
  assign imm_zx  = {16'h0000, imm16};
  assign sum     = A + B;
  assign diff    = A - B;
  assign imm_sum = A + imm_sx;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_op_e'(ALUoper))
      OP_AND:   result = A & B;
      OP_OR:    result = A | B;
      OP_ADD: begin
        result = sum;
        ovf    = (A[31] == B[31]) && (sum[31] != A[31]);
      end
      OP_SLL:   result = B << shamt;
      OP_SRL:   result = B >> shamt;
      OP_SRA:   result = $signed(B) >>> shamt;
      OP_SUB: begin
        result = diff;
        ovf    = (A[31] != B[31]) && (diff[31] != A[31]);
      end
      OP_SLT:   result = {31'b0, $signed(A) < $signed(B)};
      OP_NOR:   result = ~(A | B);
      OP_XOR:   result = A ^ B;
      OP_ADDU:  result = sum;
      OP_SLTU:  result = {31'b0, A < B};
      OP_SLLV:  result = B << A[4:0];
      OP_SRLV:  result = B >> A[4:0];
      OP_SUBU:  result = diff;
      OP_SRAV:  result = $signed(B) >>> A[4:0];
      OP_ADDIU: result = imm_sum;
      OP_XORI:  result = A ^ imm_zx;
      OP_LUI:   result = {imm16, 16'h0000};
      OP_SLTI:  result = {31'b0, $signed(A) < $signed(imm_sx)};
      OP_SLTIU: result = {31'b0, A < imm_sx};
      default:  result = '0;
    endcase
  end

  // A stalled instruction only faults on the cycle it actually advances.
  assign fault    = in_valid && !flush && !stall && ovf;
  assign take_exc = fault && (!exc_pending || exc_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_wreg    <= 1'b0;
      out_waddr   <= '0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      exc_pending <= 1'b0;
      exc_epc     <= '0;
    end else begin
      if (flush) begin
        out_valid  <= 1'b0;
        out_wreg   <= 1'b0;
        out_waddr  <= in_waddr;
        out_result <= result;
        out_zero   <= (result == '0);
      end else if (!stall) begin
        out_valid  <= in_valid;
        out_wreg   <= in_valid && in_wreg && !ovf;
        out_waddr  <= in_waddr;
        out_result <= result;
        out_zero   <= (result == '0);
      end

      if (take_exc) begin
        exc_pending <= 1'b1;
        exc_epc     <= in_pc;
      end else if (exc_ack) begin
        exc_pending <= 1'b0;
      end
    end
  end

endmodule
